// File: rtl/clahe_phase_ctrl_if.sv
// ---------------------------------------------------------------------------
// clahe_phase_ctrl_if
//   Handshake bundle between the CLAHE per-frame phase sequencer and the
//   post-processing engines / capture front end.
//
//   master : the sequencer (clahe_phase_ctrl)
//   slave  : the environment (capture, clear/clip/redist/CDF engines, CSRs)
//
//   frame_end       capture -> seq   1-cycle end-of-frame pulse
//   cfg_enable      csr     -> seq   gate for starting new frames
//   cfg_clip_limit  csr     -> seq   requested clip threshold per bin
//   err_clr         csr     -> seq   clears the sticky timeout flag
//   *_done          engine  -> seq   1-cycle phase completion pulses
//   area_flag       seq     -> eng   histogram ping-pong bank select
//   constract_th    seq     -> clip  clip threshold latched per frame
//   *_start         seq     -> eng   1-cycle phase start pulses
//   busy/map_*/err_timeout/overrun_cnt/state_dbg   status outputs
// ---------------------------------------------------------------------------
interface clahe_phase_ctrl_if;
  logic        frame_end;
  logic        cfg_enable;
  logic [15:0] cfg_clip_limit;
  logic        err_clr;
  logic        clear_done;
  logic        clip_done;
  logic        redist_done;
  logic        cdf_done;

  logic        area_flag;
  logic [15:0] constract_th;
  logic        clear_start;
  logic        redist_start;
  logic        cdf_start;
  logic        busy;
  logic        map_valid;
  logic        map_bank;
  logic        err_timeout;
  logic [7:0]  overrun_cnt;
  logic [2:0]  state_dbg;

  modport master (
    input  frame_end, cfg_enable, cfg_clip_limit, err_clr,
           clear_done, clip_done, redist_done, cdf_done,
    output area_flag, constract_th, clear_start, redist_start, cdf_start,
           busy, map_valid, map_bank, err_timeout, overrun_cnt, state_dbg
  );

  modport slave (
    output frame_end, cfg_enable, cfg_clip_limit, err_clr,
           clear_done, clip_done, redist_done, cdf_done,
    input  area_flag, constract_th, clear_start, redist_start, cdf_start,
           busy, map_valid, map_bank, err_timeout, overrun_cnt, state_dbg
  );
endinterface

// File: rtl/clahe_phase_ctrl.sv
// ---------------------------------------------------------------------------
// clahe_phase_ctrl
//   Per-frame sequencer for the CLAHE tile-histogram post-processing chain.
//   On an accepted frame end it latches the clip threshold, swaps the
//   histogram ping-pong bank and then walks clear -> clip -> redistribute ->
//   CDF, publishing the bank that holds finished mapping tables. Every wait
//   phase is guarded by a timeout; frame ends that arrive while busy are
//   dropped and counted.
//
//   clk  : system clock
//   rst  : asynchronous reset, active-high
//   bus  : clahe_phase_ctrl_if.master (see interface header for signals)
//
//   Parameters
//     TIMEOUT_CYC : max cycles in any wait state before abort
//     TO_W        : timeout counter width, 2**TO_W >= TIMEOUT_CYC
// ---------------------------------------------------------------------------
module clahe_phase_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 8192,
  parameter int unsigned TO_W        = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  clahe_phase_ctrl_if.master    bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SWAP   = 3'd1;
  localparam logic [2:0] S_W_CLR  = 3'd2;
  localparam logic [2:0] S_W_CLIP = 3'd3;
  localparam logic [2:0] S_W_RED  = 3'd4;
  localparam logic [2:0] S_W_CDF  = 3'd5;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [2:0]      state_q,        state_d;
  logic [TO_W-1:0] to_cnt_q,       to_cnt_d;
  logic            area_flag_q,    area_flag_d;
  logic [15:0]     th_q,           th_d;
  logic            clear_start_q,  clear_start_d;
  logic            redist_start_q, redist_start_d;
  logic            cdf_start_q,    cdf_start_d;
  logic            map_valid_q,    map_valid_d;
  logic            map_bank_q,     map_bank_d;
  logic            err_q,          err_d;
  logic [7:0]      ovr_q,          ovr_d;

  logic            in_wait;
  logic            to_expired;
  logic            timeout;

  assign in_wait    = (state_q == S_W_CLR) || (state_q == S_W_CLIP) ||
                      (state_q == S_W_RED) || (state_q == S_W_CDF);
  assign to_expired = (to_cnt_q == TO_LAST);

  // Next-state and datapath decode. A done pulse is only looked at in its
  // own wait state, so early/late pulses for other phases fall through.
  // NOTE: every signal assigned in this block gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    th_d           = th_q;
    area_flag_d    = area_flag_q;
    clear_start_d  = 1'b0;
    redist_start_d = 1'b0;
    cdf_start_d    = 1'b0;
    map_valid_d    = map_valid_q;
    map_bank_d     = map_bank_q;
    timeout        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.frame_end && bus.cfg_enable) begin
          // A zero threshold would clip every bin to nothing; floor at 1.
          th_d    = (bus.cfg_clip_limit == 16'd0) ? 16'd1 : bus.cfg_clip_limit;
          state_d = S_SWAP;
        end
      end
      S_SWAP: begin
        area_flag_d   = ~area_flag_q;
        map_valid_d   = 1'b0;
        clear_start_d = 1'b1;
        state_d       = S_W_CLR;
      end
      S_W_CLR: begin
        if (bus.clear_done) begin
          // The clipper starts itself off clear_done; no pulse from here.
          state_d = S_W_CLIP;
        end else if (to_expired) begin
          timeout = 1'b1;
        end
      end
      S_W_CLIP: begin
        if (bus.clip_done) begin
          redist_start_d = 1'b1;
          state_d        = S_W_RED;
        end else if (to_expired) begin
          timeout = 1'b1;
        end
      end
      S_W_RED: begin
        if (bus.redist_done) begin
          cdf_start_d = 1'b1;
          state_d     = S_W_CDF;
        end else if (to_expired) begin
          timeout = 1'b1;
        end
      end
      S_W_CDF: begin
        if (bus.cdf_done) begin
          map_valid_d = 1'b1;
          map_bank_d  = area_flag_q;
          state_d     = S_IDLE;
        end else if (to_expired) begin
          timeout = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort leaves map_valid low (cleared in SWAP) and issues no start.
    if (timeout) begin
      state_d = S_IDLE;
    end
  end

  // Timeout counter restarts on every state change and only runs in the
  // wait states; abort fires before it can wrap.
  always_comb begin
    to_cnt_d = '0;
    if ((state_d == state_q) && in_wait) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  // Sticky error: a new timeout beats a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (timeout) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end
  end

  // Any frame end seen outside IDLE is dropped, including the cycle that
  // leaves W_CDF; the count saturates rather than wrapping.
  always_comb begin
    ovr_d = ovr_q;
    if (bus.frame_end && (state_q != S_IDLE) && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  // NOTE: all control and status registers reset, so a mid-sequence reset
  // leaves nothing in flight and no start pulse can follow its release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      to_cnt_q       <= '0;
      area_flag_q    <= 1'b0;
      th_q           <= 16'd0;
      clear_start_q  <= 1'b0;
      redist_start_q <= 1'b0;
      cdf_start_q    <= 1'b0;
      map_valid_q    <= 1'b0;
      map_bank_q     <= 1'b0;
      err_q          <= 1'b0;
      ovr_q          <= 8'd0;
    end else begin
      state_q        <= state_d;
      to_cnt_q       <= to_cnt_d;
      area_flag_q    <= area_flag_d;
      th_q           <= th_d;
      clear_start_q  <= clear_start_d;
      redist_start_q <= redist_start_d;
      cdf_start_q    <= cdf_start_d;
      map_valid_q    <= map_valid_d;
      map_bank_q     <= map_bank_d;
      err_q          <= err_d;
      ovr_q          <= ovr_d;
    end
  end

  assign bus.area_flag    = area_flag_q;
  assign bus.constract_th = th_q;
  assign bus.clear_start  = clear_start_q;
  assign bus.redist_start = redist_start_q;
  assign bus.cdf_start    = cdf_start_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.map_valid    = map_valid_q;
  assign bus.map_bank     = map_bank_q;
  assign bus.err_timeout  = err_q;
  assign bus.overrun_cnt  = ovr_q;
  assign bus.state_dbg    = state_q;

endmodule
